counter_dff_ripple_up: RTL and testbench
========================================

// Module: counter_dff_ripple_up
//
// PURPOSE
// - Asynchronous (ripple) binary up-counter built from a chain of D flip-flops, default 4 bits.
// - Each stage is a toggle flop (D = ~Q). Stage 0 is clocked by Clk; stage i>0 is clocked by the
//   complement of stage i-1's output.
// - A leaf utility counter for low-speed event counting and clock division.
// - Outputs settle by ripple, not all at once.
//
// PARAMETERS
// - WIDTH   4   number of ripple stages / width of count (>=1)
//
// PORTS
// - Clk     in   1      counting clock; stage 0 advances on the rising edge
// - Clr     in   1      asynchronous, active-high clear of all stages
// - count   out  WIDTH  current count; count[0] is the LSB (stage 0)
// - tc      out  1      terminal count; only present with RIPPLE_TC_OUT_EN
//
// BEHAVIOUR
// - Reset
//   - Clr=1 forces every stage Q=0 immediately, independent of Clk, so count=0 (tc=0).
//   - While Clr=1, Clk edges are ignored and count holds 0.
// - Counting
//   - With Clr=0, each rising Clk edge toggles stage 0.
//   - Stage i toggles on the rising edge of ~Q[i-1], i.e. when Q[i-1] falls 1->0.
//   - Net effect: count increments by 1 per rising Clk edge.
// - Latency
//   - count[0] updates one flop delay after the Clk edge; count[i] updates i+1 flop delays after it.
//   - Intermediate ripple values (e.g. 0111->0110->0100->0000->1000) are legal transients.
//   - In zero-delay simulation, the final value is stable within the same timestep.
// - Wrap-around: count = 2^WIDTH-1 (4'b1111) plus one rising edge gives 0. No saturation, no carry port.
// - Clr release coinciding with a rising Clk edge: that edge is ignored; the count starts from 0
//   on the next rising edge.
// - Clr mid-operation: count drops to 0 at once, even during a ripple in progress. No partial update
//   survives.
// - Falling Clk edges never change count.
// - Each stage is a separate always block with an asynchronous clear. No combinational paths from
//   Clk to count.
//
// CONFIGURATION
// - Optional feature macro: RIPPLE_TC_OUT_EN.
// - When defined:
//   - Adds output port tc.
//   - tc = &count (1 exactly when count = 2^WIDTH-1). Combinational, decoded from the settled stage
//     outputs.
//   - tc is 0 during reset.
// - When undefined: no tc port; port list is exactly (count, Clk, Clr).
//
// TESTING (Clk period 40 ns, toggling every 20 ns, starting low; rising edges at 20, 60, 100, ...)
// - Power-up reset: Clr=1 from t=0 to 45 -> count=0000 throughout; the edge at 20 is ignored.
// - Count-up: Clr=0 at 45 -> count=0001 after the edge at 60, 0010 at 100, 0011 at 140;
//   15 edges reach 1111 at 620.
// - Wrap-around: the next rising edge at 660 -> count=0000; the edge at 700 -> 0001.
// - Async clear mid-count:
//   - Pulse Clr=1 at t=230 (count=0101) -> count=0000 at 230, with no clock edge needed.
//   - Release at 250 -> count=0001 after the edge at 260.
// - Clr/edge coincidence: release Clr exactly at a rising edge -> count stays 0000 until the
//   following rising edge gives 0001.
// - With RIPPLE_TC_OUT_EN: tc=1 only while count=1111 (t 620-660); tc=0 under Clr and at all
//   other counts.

Source files
------------

// File: rtl/counter_dff_ripple_up.sv
// Ripple binary up-counter: a chain of toggle flops, each stage clocked by the inverted output of the
// previous one. Optional terminal-count output enabled by defining RIPPLE_TC_OUT_EN.
module counter_dff_ripple_up #(
  parameter int WIDTH = 4
) (
  output logic [WIDTH-1:0] count,
  input  logic             Clk,
  input  logic             Clr
`ifdef RIPPLE_TC_OUT_EN
  ,
  output logic             tc
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic stage_clk;
    logic bit_q;
    logic bit_d;

    // Stage i advances when stage i-1 falls 1->0, i.e. on the rising edge of its complement.
    if (i == 0) begin : g_first
      assign stage_clk = Clk;
    end else begin : g_next
      assign stage_clk = ~g_stage[i-1].bit_q;
    end

    always_comb begin
      bit_d = ~bit_q;
    end

    always_ff @(posedge stage_clk or posedge Clr) begin
      if (Clr) begin
        bit_q <= 1'b0;
      end else begin
        bit_q <= bit_d;
      end
    end

    assign count[i] = bit_q;
  end

`ifdef RIPPLE_TC_OUT_EN
  // Decoded from settled stage outputs; the clear forces count to 0, so tc is low under Clr.
  assign tc = &count;
`endif

endmodule

// File: tb/tb_counter_dff_ripple_up.sv
// Self-checking bench for counter_dff_ripple_up: directed power-up/count/wrap sequence followed by
// randomized counting, clear pulses, clear held across edges and clear release on a rising edge.
module tb_counter_dff_ripple_up;
  localparam int WIDTH = 4;
  localparam int MOD   = 1 << WIDTH;

  logic             Clk = 1'b0;
  logic             Clr = 1'b1;
  logic [WIDTH-1:0] count;
`ifdef RIPPLE_TC_OUT_EN
  logic             tc;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  int exp_cnt  = 0;

  counter_dff_ripple_up #(.WIDTH(WIDTH)) dut (
    .count (count),
    .Clk   (Clk),
    .Clr   (Clr)
`ifdef RIPPLE_TC_OUT_EN
    ,
    .tc    (tc)
`endif
  );

  always #20 Clk = ~Clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errs++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk(tag, int'(count), exp_cnt);
`ifdef RIPPLE_TC_OUT_EN
    chk({tag, "_tc"}, int'(tc), (exp_cnt == MOD - 1) ? 1 : 0);
`endif
  endtask

  // One rising edge: the model counts only if the clear is low, then the falling edge must not move it.
  task automatic cycle(input string tag);
    @(posedge Clk);
    if (!Clr) exp_cnt = (exp_cnt + 1) % MOD;
    #5;
    chk_outputs({tag, "_rise"});
    @(negedge Clk);
    #5;
    chk_outputs({tag, "_fall"});
  endtask

  // Asynchronous clear pulse entirely between rising edges.
  task automatic clear_pulse();
    Clr = 1'b1;
    #1;
    exp_cnt = 0;
    chk_outputs("async_clr");
    #4;
    Clr = 1'b0;
  endtask

  // Clear asserted across a rising edge: that edge must be ignored.
  task automatic clear_hold();
    Clr = 1'b1;
    exp_cnt = 0;
    cycle("clr_hold");
    Clr = 1'b0;
  endtask

  // Clear released in the same timestep as a rising edge; the release lands after the edge is seen.
  task automatic clear_coincide();
    Clr = 1'b1;
    exp_cnt = 0;
    #1;
    chk_outputs("coin_clr");
    @(posedge Clk);
    Clr <= 1'b0;
    #5;
    chk_outputs("coin_edge");
    cycle("coin_next");
  endtask

  initial begin
    // Power-up reset spanning the edge at 20.
    #10;
    chk_outputs("por_10");
    #20;
    chk_outputs("por_30");
    #15;
    Clr = 1'b0;

    // Edges 60..620 bring the count to 1111, then wrap at 660 and 0001 at 700.
    for (int i = 0; i < 15; i++) cycle("count_up");
    chk("full_at_620", int'(count), MOD - 1);
    cycle("wrap");
    chk("wrap_zero", int'(count), 0);
    cycle("after_wrap");

    // Count to 0101 then clear mid-count and resume.
    for (int i = 0; i < 4; i++) cycle("pre_clr");
    clear_pulse();
    cycle("post_clr");

    clear_coincide();
    clear_hold();

    for (int n = 0; n < 160; n++) begin
      int r;
      r = $urandom_range(0, 11);
      case (r)
        0:       clear_pulse();
        1:       clear_hold();
        2:       clear_coincide();
        default: cycle("rand");
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
